syn_fifo_prog: RTL

Parametrised single-clock FIFO, the next generation of the team's synchronous FIFO.
- Width and depth are configurable, with a live fill count and programmable almost-full / almost-empty thresholds.
- Registered overflow / underflow error pulses.
- Build-time choice between registered-read and first-word-fall-through output.
- Used as the general-purpose rate/burst buffer between streaming producer and consumer blocks on one clock.

---
 rtl/syn_fifo_prog.sv | 130 +++++++++++++
 1 files changed

// File: rtl/syn_fifo_prog.sv
// syn_fifo_prog: single-clock FIFO with a live fill count, programmable
// almost-full / almost-empty thresholds and registered overflow / underflow
// pulses.
// Build option: define SYN_FIFO_FWFT_EN for first-word-fall-through output;
// without it, data_out is registered and updates one cycle after a pop.
module syn_fifo_prog #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AW       = $clog2(DEPTH),
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_en,
  input  logic              read_en,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [AW:0]       count,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [AW:0] DepthC = (AW + 1)'(DEPTH);
  localparam logic [AW:0] AfLvl  = (AW + 1)'(AF_LEVEL);
  localparam logic [AW:0] AeLvl  = (AW + 1)'(AE_LEVEL);
  localparam logic [AW:0] One    = {{AW{1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic        overflow_q, overflow_d;
  logic        underflow_q, underflow_d;
  logic        push, pop;

  // Flag decodes of the registered count; acceptance uses these pre-edge values.
  always_comb begin
    full         = (count_q == DepthC);
    empty        = (count_q == '0);
    almost_full  = (count_q >= AfLvl);
    almost_empty = (count_q <= AeLvl);
    count        = count_q;
    overflow     = overflow_q;
    underflow    = underflow_q;
  end

  // Accept / reject requests and compute next pointers, count and error pulses.
  always_comb begin
    push        = write_en & ~full;
    pop         = read_en & ~empty;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = write_en & full;
    underflow_d = read_en & empty;
    if (push) begin
      wr_ptr_d = wr_ptr_q + One;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + One;
    end
    if (push && !pop) begin
      count_d = count_q + One;
    end else if (pop && !push) begin
      count_d = count_q - One;
    end
  end

  // Control state, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array; deliberately not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q[AW-1:0]] <= data_in;
    end
  end

`ifdef SYN_FIFO_FWFT_EN
  // Head word shown combinationally; read_en acknowledges it.
  always_comb begin
    data_out = '0;
    if (!empty) begin
      data_out = mem[rd_ptr_q[AW-1:0]];
    end
  end
`else
  logic [DATA_W-1:0] dout_q, dout_d;

  // Registered read: capture the head word on an accepted pop, else hold.
  always_comb begin
    dout_d = dout_q;
    if (pop) begin
      dout_d = mem[rd_ptr_q[AW-1:0]];
    end
  end

  // Output register, cleared with the rest of the control state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign data_out = dout_q;
`endif

endmodule
